// File: rtl/a5_pkg.sv
// Shared definitions for the A5 ALU sequencer.
// Opcodes, instruction fields, FSM states and opcode classifiers.
package a5_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 8;
  localparam int IDX_W  = 2;
  localparam int NREGS  = 4;

  localparam logic [OP_W-1:0] OP_NOP    = 8'h00;
  localparam logic [OP_W-1:0] OP_ADD    = 8'h71;
  localparam logic [OP_W-1:0] OP_AND    = 8'h72;
  localparam logic [OP_W-1:0] OP_CLR    = 8'h73;
  localparam logic [OP_W-1:0] OP_CLB    = 8'h74;
  localparam logic [OP_W-1:0] OP_NOT    = 8'h75;
  localparam logic [OP_W-1:0] OP_INC    = 8'h76;
  localparam logic [OP_W-1:0] OP_DEC    = 8'h77;
  localparam logic [OP_W-1:0] OP_BIT_78 = 8'h78;
  localparam logic [OP_W-1:0] OP_BIT_79 = 8'h79;
  localparam logic [OP_W-1:0] OP_BIT_7A = 8'h7A;
  localparam logic [OP_W-1:0] OP_BIT_7B = 8'h7B;
  localparam logic [OP_W-1:0] OP_BIT_7C = 8'h7C;
  localparam logic [OP_W-1:0] OP_BIT_7D = 8'h7D;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  function automatic logic is_legal(
    input logic [OP_W-1:0] op
  );
    return (op >= OP_ADD) && (op <= OP_BIT_7D);
  endfunction

  // Arithmetic/logic class; bit ops keep flags.
  function automatic logic updates_flags(
    input logic [OP_W-1:0] op
  );
    return (op >= OP_ADD) && (op <= OP_DEC);
  endfunction

endpackage

// File: rtl/a5_regfile.sv
// 4x16 register file: two combinational read ports, debug read port,
// one synchronous write port, synchronous active-high reset to zero.
module a5_regfile
  import a5_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ra_addr,
  input  logic [IDX_W-1:0]  rb_addr,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/a5_alu_sequencer.sv
// Issue/write-back controller for the A5 ALU: IDLE -> ISSUE -> CAPTURE.
// Ports: instr handshake, done/err/wb_data, flags, debug regfile port, ALU bus.
module a5_alu_sequencer
  import a5_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_c,
  output logic              flag_z,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] alu_read_a,
  output logic [DATA_W-1:0] alu_read_b,
  output logic [OP_W-1:0]   alu_opcode2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero
);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;

  logic              rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;

  logic [OP_W-1:0]  op;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] ra_idx;
  logic [IDX_W-1:0] rb_idx;
  logic             legal;

  assign op     = instr_q[OPC_MSB:OPC_LSB];
  assign rd_idx = instr_q[RD_MSB:RD_LSB];
  assign ra_idx = instr_q[RA_MSB:RA_LSB];
  assign rb_idx = instr_q[RB_MSB:RB_LSB];
  assign legal  = is_legal(op);

  a5_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (ra_idx),
    .rb_addr  (rb_idx),
    .dbg_addr (dbg_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    wb_data     = '0;
    alu_read_a  = '0;
    alu_read_b  = '0;
    alu_opcode2 = OP_NOP;
    rf_we       = 1'b0;
    rf_waddr    = dbg_addr;
    rf_wdata    = dbg_wdata;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        // Debug preload shares the write port; no
        // write-back can happen in IDLE.
        rf_we = dbg_we;
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_read_a = ra_data;
        alu_read_b = rb_data;
        // NOP keeps the ALU holding its last outputs.
        alu_opcode2 = legal ? op : OP_NOP;
        state_d     = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        done    = 1'b1;
        err     = ~legal;
        wb_data = alu_result;
        if (legal) begin
          rf_we    = 1'b1;
          rf_waddr = rd_idx;
          rf_wdata = alu_result;
          if (updates_flags(op)) begin
            flag_c_d = alu_carry;
            flag_z_d = alu_zero;
          end
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;

endmodule

// File: tb/tb_a5_alu_sequencer.sv
// Scoreboard bench for a5_alu_sequencer with a stand-in registered ALU.
// Directed test-plan sequence followed by randomized instructions.
module tb_a5_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        done;
  logic        err;
  logic [15:0] wb_data;
  logic        flag_c;
  logic        flag_z;
  logic [1:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic        dbg_we = 1'b0;
  logic [15:0] dbg_wdata = '0;
  logic [15:0] alu_read_a;
  logic [15:0] alu_read_b;
  logic [7:0]  alu_opcode2;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  a5_alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .done        (done),
    .err         (err),
    .wb_data     (wb_data),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dbg_we      (dbg_we),
    .dbg_wdata   (dbg_wdata),
    .alu_read_a  (alu_read_a),
    .alu_read_b  (alu_read_b),
    .alu_opcode2 (alu_opcode2),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero)
  );

  // A5 ALU behaviour: {carry, zero, result}. Its zero line is
  // high for a non-zero result.
  function automatic logic [17:0] alu_fn(
    input logic [7:0]  op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    r = '0;
    case (op)
      8'h71: begin s = a + b; r = s[15:0]; c = s[16]; end
      8'h72: r = a & b;
      8'h73: r = '0;
      8'h74: r = a & ~b;
      8'h75: r = ~a;
      8'h76: begin s = b + 1; r = s[15:0]; c = s[16]; end
      8'h77: begin r = b - 1; c = (b == 0); end
      8'h78: r = a | 16'h0100;
      8'h79: r = a & ~16'h0100;
      8'h7A: r = a | 16'h2000;
      8'h7B: r = a & ~16'h2000;
      8'h7C: r = a ^ 16'h8000;
      8'h7D: r = a ^ 16'h0001;
      default: r = '0;
    endcase
    return {c, |r, r};
  endfunction

  // Stand-in ALU: registered, no reset, holds on unknown opcodes.
  always @(posedge clk) begin
    if (alu_opcode2 >= 8'h71 && alu_opcode2 <= 8'h7D) begin
      {alu_carry, alu_zero, alu_result} <=
        alu_fn(alu_opcode2, alu_read_a, alu_read_b);
    end
  end

  typedef struct {
    int          done_cyc;
    logic [15:0] wb;
    bit          err;
    bit          fc;
    bit          fz;
  } exp_t;

  exp_t sb[$];

  logic [15:0] m_reg [4];
  logic [15:0] m_alu = '0;
  bit          m_fc = 0;
  bit          m_fz = 0;

  task automatic chk(
    input string       name,
    input logic [15:0] act,
    input logic [15:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: bus idle rule plus retire checks popped from the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (instr_ready || done)) begin
        chk("opcode_idle", {8'h0, alu_opcode2}, 16'h0);
        chk("opa_idle", alu_read_a, 16'h0);
        chk("opb_idle", alu_read_b, 16'h0);
      end
      if (!rst && done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {15'h0, done}, 16'h0);
        end else begin
          e = sb.pop_front();
          chk("latency", 16'(cyc), 16'(e.done_cyc));
          chk("wb_data", wb_data, e.wb);
          chk("err", {15'h0, err}, {15'h0, e.err});
          chk("ready_capture", {15'h0, instr_ready}, 16'h0);
          @(negedge clk);
          chk("flag_c", {15'h0, flag_c}, {15'h0, e.fc});
          chk("flag_z", {15'h0, flag_z}, {15'h0, e.fz});
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 16'h0, 16'h1);
  endtask

  task automatic dbg_write(
    input logic [1:0]  a,
    input logic [15:0] d
  );
    wait_ready();
    dbg_we = 1'b1;
    dbg_addr = a;
    dbg_wdata = d;
    @(posedge clk);
    #1 dbg_we = 1'b0;
    m_reg[a] = d;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk($sformatf("reg%0d", i), dbg_data, m_reg[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_fc = 0;
    m_fz = 0;
  endtask

  task automatic issue(
    input logic [15:0] ins,
    input bit          keep,
    input logic [15:0] nxt,
    input bit          dw,
    input bit          poke
  );
    exp_t        e;
    logic [7:0]  op;
    logic [1:0]  rd;
    logic [15:0] old;
    logic [17:0] res;
    bit          legal;
    wait_ready();
    instr_valid = 1'b1;
    instr = ins;
    if (dw) begin
      dbg_we = 1'b1;
      dbg_addr = 2'($urandom);
      dbg_wdata = 16'($urandom);
      m_reg[dbg_addr] = dbg_wdata;
    end
    op = ins[15:8];
    rd = ins[7:6];
    legal = op >= 8'h71 && op <= 8'h7D;
    old = m_reg[rd];
    if (legal) begin
      res = alu_fn(op, m_reg[ins[5:4]], m_reg[ins[3:2]]);
      m_alu = res[15:0];
      m_reg[rd] = res[15:0];
      if (op <= 8'h77) begin
        m_fc = res[17];
        m_fz = res[16];
      end
    end
    e.done_cyc = cyc + 2;
    e.wb = m_alu;
    e.err = !legal;
    e.fc = m_fc;
    e.fz = m_fz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    dbg_we = poke;
    dbg_addr = 2'($urandom);
    dbg_wdata = 16'($urandom);
    if (keep) instr = nxt;
    else begin
      instr_valid = 1'b0;
      instr = 16'($urandom);
    end
    chk("ready_issue", {15'h0, instr_ready}, 16'h0);
    @(posedge clk);
    #1;
    if (legal && !poke) begin
      dbg_addr = rd;
      #1 chk("dbg_prewrite", dbg_data, old);
    end
    @(posedge clk);
    #1 dbg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 16'(sb.size()), 16'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  op;
    logic [7:0]  fld;
    logic [17:0] res;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {15'h0, instr_ready}, 16'h1);
    chk("rst_done", {14'h0, done, err}, 16'h0);
    chk("rst_wb", wb_data, 16'h0);
    chk("rst_flags", {14'h0, flag_c, flag_z}, 16'h0);
    check_regs();

    dbg_write(2'd1, 16'hFFFF);
    dbg_write(2'd2, 16'h0001);
    issue(16'h7118, 0, 16'h0, 0, 0);
    issue(16'h76C8, 0, 16'h0, 0, 0);
    issue(16'h7A20, 0, 16'h0, 0, 0);
    issue(16'h7E00, 0, 16'h0, 0, 0);
    drain();
    chk("plan_r0", m_reg[0], 16'h2001);
    chk("plan_r3", m_reg[3], 16'h0002);
    chk("plan_flags", {14'h0, flag_c, flag_z}, 16'h1);
    check_regs();

    // Reset during ISSUE: the ALU still registers the issued op.
    wait_ready();
    instr_valid = 1'b1;
    instr = 16'h7118;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    rst = 1'b1;
    res = alu_fn(8'h71, m_reg[1], m_reg[2]);
    m_alu = res[15:0];
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_ready", {15'h0, instr_ready}, 16'h1);
    chk("abort_done", {15'h0, done}, 16'h0);
    repeat (3) @(negedge clk);
    chk("abort_flags", {14'h0, flag_c, flag_z}, 16'h0);
    check_regs();

    dbg_write(2'd1, 16'hFFFF);
    dbg_write(2'd2, 16'h0001);
    issue(16'h7118, 1, 16'h7104, 0, 0);
    issue(16'h7104, 0, 16'h0, 0, 0);
    drain();
    chk("b2b_r0", m_reg[0], 16'hFFFF);
    check_regs();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 8) op = 8'($urandom_range(8'h71, 8'h7D));
      else op = 8'($urandom);
      fld = 8'($urandom);
      issue({op, fld}, 0, 16'h0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0);
    end
    drain();
    check_regs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1);
  end

endmodule
